ddr3_cmd_bridge: RTL and testbench
==================================

Name: ddr3_cmd_bridge

Overview:
Sits directly downstream of the frame/cache memory controller, on its alex* command interface. Converts the held-request/acknowledge-pulse protocol into the DDR3 MIG native app interface (app_cmd/app_en/app_rdy, write-data FIFO, read-return channel). Tracks outstanding reads and returns their data in order as single-cycle completion pulses. Runs in the 200 MHz controller domain.

Parameters:
ADDR_W, 27, upstream address width
APP_ADDR_W, 28, MIG app_addr width; upstream address zero-extended
MAX_RD, 8, maximum outstanding reads (power of two, 2..32)
RD_TIMEOUT, 1024, cycles without read return before timeout (optional feature only)

Ports:
clk  in  1  sole clock
reset  in  1  asynchronous, active-high
alexAddress  in  ADDR_W  request address
alexWriteData  in  128  write data
alexMemEnable  in  2  01 read, 10 write; 00/11 ignored
alexWriteBytes  in  8  bit i enables 16-bit halfword i
alexNewCommand  in  1  request valid, level
alexCommandAcknowledged  out  1  request captured, one-cycle pulse
alexReadData  out  128  read return data
alexFinishedMemAction  out  1  read data valid, one-cycle pulse
app_addr  out  APP_ADDR_W
app_cmd  out  3  000 write, 001 read
app_en  out  1
app_rdy  in  1
app_wdf_data  out  128
app_wdf_mask  out  16  active-low byte enables
app_wdf_wren  out  1
app_wdf_end  out  1  always equal to app_wdf_wren
app_wdf_rdy  in  1
app_rd_data  in  128
app_rd_data_valid  in  1
init_calib_complete  in  1
readTimeoutError  out  1  sticky

Behaviour:
- Reset values: all outputs 0; holding register empty; read count 0; flags cleared. Asynchronous reset mid-transfer abandons the held command. Any app_rd_data_valid arriving while read count is 0 is dropped: no pulse.
- Holding register (one entry): addr, cmd, data, mask, flags cmdDone/dataDone.
- Capture condition (combinational ack), all of:
  - alexNewCommand=1
  - alexMemEnable is 01 or 10
  - init_calib_complete=1
  - holding empty, or holding retiring this cycle
  - for reads: readCount + pending reservation < MAX_RD
- alexCommandAcknowledged=1 exactly in the capture cycle; inputs are sampled at that edge. Level-high alexNewCommand with a new address each cycle gives one command per cycle when app_rdy stays high.
- Read capture: readCount increments at capture. A read accepted by the MIG on app_en&app_rdy retires the holding entry.
- Write capture:
  - Posted write; no alexFinishedMemAction is generated.
  - app_wdf_mask[2i+1:2i] = {2{~alexWriteBytes[i]}}.
  - app_en and app_wdf_wren assert from the cycle after capture.
  - Command and data handshakes complete independently and set cmdDone/dataDone. Each output deasserts once its own flag is set.
  - The entry retires when both handshakes are done, including both completing in the same cycle.
- States:
  - CALIB: wait for init_calib_complete; go to RUN.
  - RUN: normal operation.
  - If init_calib_complete drops, go to CALIB. No new captures; the held entry still completes.
- Read return: on app_rd_data_valid with readCount>0, register app_rd_data into alexReadData and pulse alexFinishedMemAction the next cycle (latency 1). readCount decrements.
- A capture and a return in the same cycle leave readCount unchanged.
- alexReadData holds its value between pulses.
- Returns are in order (MIG guarantee); no tags.

Optional Feature:
Macro READ_TIMEOUT_EN.
- Defined: a counter runs while readCount>0, clearing on each app_rd_data_valid. When it reaches RD_TIMEOUT, readTimeoutError sets and stays set until reset.
- Undefined: readTimeoutError is tied to 0 and no counter is built.

Test Plan:
- Calibration gate: init_calib_complete=0, read request held 20 cycles -> no ack, app_en=0. Raise calib -> ack within 1 cycle, app_cmd=001.
- Read: read at 0x0000100, app_rdy=1, MIG returns 0xDEAD...BEEF 5 cycles later -> app_addr=0x0000100, one alexFinishedMemAction pulse, alexReadData=0xDEAD...BEEF.
- Write: alexWriteBytes=0x81, app_rdy=1, app_wdf_rdy delayed 3 cycles -> app_wdf_mask=0x3FFC, ack once, app_en deasserts after 1 cycle, wren held 3 cycles, no finished pulse.
- Back-to-back burst: 512 reads with alexNewCommand level-high, MIG slow -> acks stop while readCount=8, exactly 512 acks and 512 in-order pulses.
- Simultaneous events: capture and return in the same cycle at readCount=8 -> count stays 8. Reset asserted mid-write -> outputs 0 immediately; a late rd_data_valid is dropped.
- Timeout (READ_TIMEOUT_EN): 1 read, no return for 1024 cycles -> readTimeoutError=1, still set after a later return.

Source files
------------

// File: rtl/ddr3_cmd_bridge.sv
// rtl/ddr3_cmd_bridge.sv - alex* held-request interface to DDR3 MIG native app interface bridge.
// Optional read-return watchdog enabled by defining READ_TIMEOUT_EN.
module ddr3_cmd_bridge #(
  parameter int ADDR_W     = 27,
  parameter int APP_ADDR_W = 28,
  parameter int MAX_RD     = 8,
  parameter int RD_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     alexAddress,
  input  logic [127:0]          alexWriteData,
  input  logic [1:0]            alexMemEnable,
  input  logic [7:0]            alexWriteBytes,
  input  logic                  alexNewCommand,
  output logic                  alexCommandAcknowledged,
  output logic [127:0]          alexReadData,
  output logic                  alexFinishedMemAction,
  output logic [APP_ADDR_W-1:0] app_addr,
  output logic [2:0]            app_cmd,
  output logic                  app_en,
  input  logic                  app_rdy,
  output logic [127:0]          app_wdf_data,
  output logic [15:0]           app_wdf_mask,
  output logic                  app_wdf_wren,
  output logic                  app_wdf_end,
  input  logic                  app_wdf_rdy,
  input  logic [127:0]          app_rd_data,
  input  logic                  app_rd_data_valid,
  input  logic                  init_calib_complete,
  output logic                  readTimeoutError
);

  localparam int CNT_W = $clog2(MAX_RD) + 1;

  typedef enum logic {CALIB, RUN} state_t;
  state_t state, state_nxt;

  logic                  hold_valid;
  logic [2:0]            hold_cmd;
  logic [APP_ADDR_W-1:0] hold_addr;
  logic [127:0]          hold_data;
  logic [15:0]           hold_mask;
  logic                  cmd_done;
  logic                  data_done;
  logic [CNT_W-1:0]      read_count;

  logic        is_read, is_write, hold_is_read;
  logic        cmd_fire, data_fire, retiring;
  logic        rd_return, rd_room, capture;
  logic [15:0] mask_in;

  assign is_read      = (alexMemEnable == 2'b01);
  assign is_write     = (alexMemEnable == 2'b10);
  assign hold_is_read = hold_cmd[0];

  assign app_addr     = hold_addr;
  assign app_cmd      = hold_cmd;
  assign app_wdf_data = hold_data;
  assign app_wdf_mask = hold_mask;
  assign app_en       = hold_valid & ~cmd_done;
  assign app_wdf_wren = hold_valid & ~hold_is_read & ~data_done;
  assign app_wdf_end  = app_wdf_wren;

  assign cmd_fire  = app_en & app_rdy;
  assign data_fire = app_wdf_wren & app_wdf_rdy;
  assign retiring  = hold_valid & (hold_is_read ? cmd_fire
                                   : ((cmd_done | cmd_fire) & (data_done | data_fire)));

  // A return in the same cycle frees a slot, so a full tracker can still accept one read.
  assign rd_return = app_rd_data_valid & (read_count != '0);
  assign rd_room   = (read_count - CNT_W'(rd_return)) < CNT_W'(MAX_RD);

  assign capture = alexNewCommand & (is_read | is_write) & init_calib_complete &
                   (state == RUN) & (~hold_valid | retiring) & (~is_read | rd_room);
  assign alexCommandAcknowledged = capture;

  always_comb begin
    mask_in = '0;
    for (int i = 0; i < 8; i++) begin
      mask_in[2*i +: 2] = {2{~alexWriteBytes[i]}};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= CALIB;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CALIB:   if (init_calib_complete)  state_nxt = RUN;
      RUN:     if (!init_calib_complete) state_nxt = CALIB;
      default: state_nxt = CALIB;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_valid <= 1'b0;
      hold_cmd   <= 3'b000;
      hold_addr  <= '0;
      hold_data  <= '0;
      hold_mask  <= '0;
      cmd_done   <= 1'b0;
      data_done  <= 1'b0;
    end else if (capture) begin
      hold_valid <= 1'b1;
      hold_cmd   <= is_read ? 3'b001 : 3'b000;
      hold_addr  <= APP_ADDR_W'(alexAddress);
      hold_data  <= alexWriteData;
      hold_mask  <= mask_in;
      cmd_done   <= 1'b0;
      data_done  <= 1'b0;
    end else if (retiring) begin
      hold_valid <= 1'b0;
      cmd_done   <= 1'b0;
      data_done  <= 1'b0;
    end else begin
      if (cmd_fire)  cmd_done  <= 1'b1;
      if (data_fire) data_done <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_count <= '0;
    end else begin
      case ({capture & is_read, rd_return})
        2'b10:   read_count <= read_count + 1'b1;
        2'b01:   read_count <= read_count - 1'b1;
        default: read_count <= read_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alexReadData          <= '0;
      alexFinishedMemAction <= 1'b0;
    end else begin
      alexFinishedMemAction <= rd_return;
      if (rd_return) alexReadData <= app_rd_data;
    end
  end

`ifdef READ_TIMEOUT_EN
  localparam int TO_W = $clog2(RD_TIMEOUT + 1);
  logic [TO_W-1:0] to_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_count         <= '0;
      readTimeoutError <= 1'b0;
    end else begin
      if (app_rd_data_valid)
        to_count <= '0;
      else if ((read_count != '0) && (to_count != TO_W'(RD_TIMEOUT)))
        to_count <= to_count + 1'b1;
      if (to_count == TO_W'(RD_TIMEOUT)) readTimeoutError <= 1'b1;
    end
  end
`else
  // Constant 0; the reference keeps RD_TIMEOUT in use so both builds share one parameter list.
  assign readTimeoutError = (RD_TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_ddr3_cmd_bridge.sv
// tb/tb_ddr3_cmd_bridge.sv - self-checking bench for ddr3_cmd_bridge.
module tb_ddr3_cmd_bridge;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [26:0]  alexAddress = '0;
  logic [127:0] alexWriteData = '0;
  logic [1:0]   alexMemEnable = '0;
  logic [7:0]   alexWriteBytes = '0;
  logic         alexNewCommand = 1'b0;
  logic         alexCommandAcknowledged;
  logic [127:0] alexReadData;
  logic         alexFinishedMemAction;
  logic [27:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en;
  logic         app_rdy = 1'b1;
  logic [127:0] app_wdf_data;
  logic [15:0]  app_wdf_mask;
  logic         app_wdf_wren;
  logic         app_wdf_end;
  logic         app_wdf_rdy = 1'b1;
  logic [127:0] app_rd_data = '0;
  logic         app_rd_data_valid = 1'b0;
  logic         init_calib_complete = 1'b0;
  logic         readTimeoutError;

  ddr3_cmd_bridge dut (
    .clk(clk), .reset(reset),
    .alexAddress(alexAddress), .alexWriteData(alexWriteData),
    .alexMemEnable(alexMemEnable), .alexWriteBytes(alexWriteBytes),
    .alexNewCommand(alexNewCommand), .alexCommandAcknowledged(alexCommandAcknowledged),
    .alexReadData(alexReadData), .alexFinishedMemAction(alexFinishedMemAction),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .init_calib_complete(init_calib_complete), .readTimeoutError(readTimeoutError)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  function automatic logic [127:0] data_of(input logic [26:0] a);
    return {4{{5'b0, a} ^ 32'hA5A5_0000}};
  endfunction

  typedef struct {
    logic [1:0]   me;
    logic [7:0]   wb;
    logic [26:0]  addr;
    logic [127:0] wd;
    logic         exp_ack;
    logic [15:0]  exp_mask;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int en_c, wr_c, fin_c, ack_c, end_bad;
    logic [15:0] mask_seen;
    logic got;

    vecs[0] = '{2'b01, 8'h00, 27'h0000100, 128'h0, 1'b1, 16'h0000};
    vecs[1] = '{2'b10, 8'h81, 27'h0000200, {4{32'h1234_5678}}, 1'b1, 16'h3FFC};
    vecs[2] = '{2'b00, 8'hFF, 27'h0000300, 128'h0, 1'b0, 16'h0000};
    vecs[3] = '{2'b11, 8'hFF, 27'h0000400, 128'h0, 1'b0, 16'h0000};
    vecs[4] = '{2'b10, 8'hFF, 27'h7FFFFFF, {4{32'hCAFE_F00D}}, 1'b1, 16'h0000};
    vecs[5] = '{2'b10, 8'h00, 27'h0000500, {4{32'h0BAD_0BAD}}, 1'b1, 16'hFFFF};
    vecs[6] = '{2'b01, 8'h00, 27'h7FFFFFF, {4{32'h0F0F_1234}}, 1'b1, 16'h0000};
    vecs[7] = '{2'b10, 8'h5A, 27'h0000600, {4{32'h5555_AAAA}}, 1'b1, 16'hCC33};

    // Reset state
    @(negedge clk); @(negedge clk); #1;
    chk("rst_app_en", app_en, 0);
    chk("rst_wren", app_wdf_wren, 0);
    chk("rst_ack", alexCommandAcknowledged, 0);
    chk("rst_fin", alexFinishedMemAction, 0);
    chk("rst_cmd", app_cmd, 0);
    chk("rst_addr", app_addr, 0);
    chk("rst_timeout", readTimeoutError, 0);
    reset = 1'b0;

    // Calibration gate, then the first read with a 5-cycle MIG return
    alexAddress = 27'h0000100; alexMemEnable = 2'b01; alexNewCommand = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      chk("calib_no_ack", alexCommandAcknowledged, 0);
      chk("calib_no_en", app_en, 0);
    end
    @(negedge clk); init_calib_complete = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 3 && !got; i++) begin
      @(negedge clk); #1;
      got = alexCommandAcknowledged;
    end
    chk("calib_ack", got, 1);
    @(negedge clk); alexNewCommand = 1'b0; #1;
    chk("calib_en", app_en, 1);
    chk("calib_cmd", app_cmd, 3'b001);
    chk("read_addr", app_addr, 28'h0000100);
    repeat (4) @(negedge clk);
    app_rd_data = {32'hDEAD_0000, 64'h0123_4567_89AB_CDEF, 32'h0000_BEEF};
    app_rd_data_valid = 1'b1;
    @(negedge clk); app_rd_data_valid = 1'b0; #1;
    chk("read_fin", alexFinishedMemAction, 1);
    chk("read_data", alexReadData, {32'hDEAD_0000, 64'h0123_4567_89AB_CDEF, 32'h0000_BEEF});
    @(negedge clk); #1;
    chk("read_fin_once", alexFinishedMemAction, 0);
    chk("read_data_hold", alexReadData, {32'hDEAD_0000, 64'h0123_4567_89AB_CDEF, 32'h0000_BEEF});

    // Table-driven single commands
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      alexAddress = vecs[i].addr; alexMemEnable = vecs[i].me;
      alexWriteBytes = vecs[i].wb; alexWriteData = vecs[i].wd; alexNewCommand = 1'b1;
      #1 chk($sformatf("vec%0d_ack", i), alexCommandAcknowledged, vecs[i].exp_ack);
      @(negedge clk); alexNewCommand = 1'b0; #1;
      if (vecs[i].exp_ack) begin
        chk($sformatf("vec%0d_en", i), app_en, 1);
        chk($sformatf("vec%0d_addr", i), app_addr, {1'b0, vecs[i].addr});
        chk($sformatf("vec%0d_cmd", i), app_cmd, (vecs[i].me == 2'b01) ? 3'b001 : 3'b000);
        if (vecs[i].me == 2'b10) begin
          chk($sformatf("vec%0d_wren", i), app_wdf_wren, 1);
          chk($sformatf("vec%0d_end", i), app_wdf_end, 1);
          chk($sformatf("vec%0d_mask", i), app_wdf_mask, vecs[i].exp_mask);
          chk($sformatf("vec%0d_wdata", i), app_wdf_data, vecs[i].wd);
          @(negedge clk); #1;
          chk($sformatf("vec%0d_retired", i), app_en | app_wdf_wren, 0);
          chk($sformatf("vec%0d_nofin", i), alexFinishedMemAction, 0);
        end else begin
          chk($sformatf("vec%0d_wren", i), app_wdf_wren, 0);
          @(negedge clk); app_rd_data = ~vecs[i].wd; app_rd_data_valid = 1'b1;
          @(negedge clk); app_rd_data_valid = 1'b0; #1;
          chk($sformatf("vec%0d_fin", i), alexFinishedMemAction, 1);
          chk($sformatf("vec%0d_rdata", i), alexReadData, ~vecs[i].wd);
          chk($sformatf("vec%0d_retired", i), app_en, 0);
        end
      end else begin
        chk($sformatf("vec%0d_noen", i), app_en, 0);
      end
    end

    // Write with app_wdf_rdy arriving on the third wren cycle
    @(negedge clk);
    app_wdf_rdy = 1'b0; alexMemEnable = 2'b10; alexWriteBytes = 8'h81;
    alexAddress = 27'h0000700; alexNewCommand = 1'b1;
    #1 chk("wdly_ack", alexCommandAcknowledged, 1);
    en_c = 0; wr_c = 0; fin_c = 0; ack_c = 0; end_bad = 0; mask_seen = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk); alexNewCommand = 1'b0; app_wdf_rdy = (k == 3); #1;
      if (k == 1) mask_seen = app_wdf_mask;
      en_c += int'(app_en); wr_c += int'(app_wdf_wren);
      fin_c += int'(alexFinishedMemAction); ack_c += int'(alexCommandAcknowledged);
      if (app_wdf_end !== app_wdf_wren) end_bad++;
    end
    app_wdf_rdy = 1'b1;
    chk("wdly_mask", mask_seen, 16'h3FFC);
    chk("wdly_en_cycles", en_c, 1);
    chk("wdly_wren_cycles", wr_c, 3);
    chk("wdly_no_fin", fin_c, 0);
    chk("wdly_single_ack", ack_c, 0);
    chk("wdly_end_eq_wren", end_bad, 0);

    // Fill to 8 outstanding, then capture together with a return
    alexMemEnable = 2'b01;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); alexAddress = 27'(i); alexNewCommand = 1'b1;
      #1 chk("fill_ack", alexCommandAcknowledged, 1);
    end
    @(negedge clk); alexAddress = 27'd8; #1;
    chk("full_block", alexCommandAcknowledged, 0);
    @(negedge clk); app_rd_data = 128'h1; app_rd_data_valid = 1'b1; #1;
    chk("full_cap_with_ret", alexCommandAcknowledged, 1);
    @(negedge clk); app_rd_data_valid = 1'b0; alexAddress = 27'd9; #1;
    chk("full_ret_fin", alexFinishedMemAction, 1);
    chk("count_stays_8", alexCommandAcknowledged, 0);
    alexNewCommand = 1'b0;
    fin_c = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); app_rd_data_valid = 1'b1;
      @(negedge clk); app_rd_data_valid = 1'b0; #1;
      fin_c += int'(alexFinishedMemAction);
    end
    chk("drain_8", fin_c, 8);
    @(negedge clk); app_rd_data_valid = 1'b1;
    @(negedge clk); app_rd_data_valid = 1'b0; #1;
    chk("drop_when_empty", alexFinishedMemAction, 0);

    // 512-read burst against a slow MIG model
    begin
      int acks, pulses, outstanding, maxo, viol, cyc;
      logic ret;
      logic [26:0] next_addr, a;
      logic [26:0] mig_q[$];
      logic [26:0] exp_q[$];
      acks = 0; pulses = 0; outstanding = 0; maxo = 0; viol = 0; cyc = 0;
      next_addr = 27'h0001000;
      alexMemEnable = 2'b01;
      while (pulses < 512 && cyc < 20000) begin
        @(negedge clk); cyc++;
        alexAddress = next_addr; alexNewCommand = (acks < 512);
        app_rdy = (cyc % 2 == 0);
        app_rd_data_valid = 1'b0;
        if (cyc % 3 == 0 && mig_q.size() > 0) begin
          a = mig_q.pop_front();
          app_rd_data = data_of(a); app_rd_data_valid = 1'b1;
        end
        #1;
        ret = app_rd_data_valid;
        if (alexFinishedMemAction) begin
          if (exp_q.size() > 0) chk("burst_data", alexReadData, data_of(exp_q.pop_front()));
          else chk("burst_spurious_fin", 1, 0);
          pulses++;
        end
        if (app_en && app_rdy) mig_q.push_back(app_addr[26:0]);
        if (alexCommandAcknowledged) begin
          if (outstanding - int'(ret) >= 8) viol++;
          exp_q.push_back(next_addr);
          acks++; next_addr++; outstanding++;
        end
        if (ret) outstanding--;
        if (outstanding > maxo) maxo = outstanding;
      end
      alexNewCommand = 1'b0; app_rdy = 1'b1; app_rd_data_valid = 1'b0;
      chk("burst_acks", acks, 512);
      chk("burst_pulses", pulses, 512);
      chk("burst_max_outstanding", maxo, 8);
      chk("burst_limit_violations", viol, 0);
    end

    // Asynchronous reset in the middle of a write
    @(negedge clk);
    app_rdy = 1'b0; app_wdf_rdy = 1'b0;
    alexMemEnable = 2'b10; alexWriteBytes = 8'h0F; alexAddress = 27'h0000ABC; alexNewCommand = 1'b1;
    #1 chk("rstw_ack", alexCommandAcknowledged, 1);
    @(negedge clk); alexNewCommand = 1'b0; #1;
    chk("rstw_en_before", app_en, 1);
    #1 reset = 1'b1; #1;
    chk("rstw_en", app_en, 0);
    chk("rstw_wren", app_wdf_wren, 0);
    chk("rstw_addr", app_addr, 0);
    chk("rstw_mask", app_wdf_mask, 0);
    chk("rstw_rdata", alexReadData, 0);
    @(negedge clk); reset = 1'b0; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    @(negedge clk); app_rd_data_valid = 1'b1;
    @(negedge clk); app_rd_data_valid = 1'b0; #1;
    chk("rstw_late_ret_dropped", alexFinishedMemAction, 0);
    chk("rstw_abandoned", app_en | app_wdf_wren, 0);

`ifdef READ_TIMEOUT_EN
    @(negedge clk); alexMemEnable = 2'b01; alexAddress = 27'h0000040; alexNewCommand = 1'b1;
    #1 chk("to_ack", alexCommandAcknowledged, 1);
    @(negedge clk); alexNewCommand = 1'b0; #1;
    chk("to_not_yet", readTimeoutError, 0);
    repeat (1100) @(negedge clk);
    #1 chk("to_set", readTimeoutError, 1);
    @(negedge clk); app_rd_data_valid = 1'b1;
    @(negedge clk); app_rd_data_valid = 1'b0; #1;
    chk("to_late_fin", alexFinishedMemAction, 1);
    chk("to_sticky", readTimeoutError, 1);
`else
    @(negedge clk); alexMemEnable = 2'b01; alexAddress = 27'h0000040; alexNewCommand = 1'b1;
    #1 chk("to_ack", alexCommandAcknowledged, 1);
    @(negedge clk); alexNewCommand = 1'b0;
    repeat (1100) @(negedge clk);
    #1 chk("to_tied_off", readTimeoutError, 0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
